// File: rtl/serial_fa_adder.sv
// serial_fa_adder: bit-serial adder/subtractor built on one decoder-based
// full-adder cell. Operands load in parallel, are processed LSB-first one bit
// per clock, and the result is returned in parallel with carry-out.
//
// Parameters:
//   WIDTH   operand/result width in bits (2..32)
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request, accepted only in IDLE
//   sub     0 = a+b, 1 = a-b (sampled with start)
//   a, b    operands (sampled with start)
//   busy    high while bits are being processed
//   done    one-cycle pulse when the result is complete
//   sum     result, held until the next accepted start
//   cout    final carry (for subtract, 1 = no borrow)
//   ovf     signed overflow
//
// Optional feature macro: SERIAL_FA_OVF_EN
//   defined   -> ovf reports signed overflow of the completed operation
//   undefined -> ovf is tied low and no overflow logic is built
module serial_fa_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             last_bit;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic [2:0]       dec_in;
   logic [7:0]       minterm;
   logic             s_bit;
   logic             c_bit;

   // Full-adder cell: 3-to-8 minterm decoder, sum and carry as OR of minterms
   always_comb begin
      dec_in  = {a_sh[0], b_sh[0], carry};
      minterm = 8'b0000_0001 << dec_in;
      s_bit   = minterm[1] | minterm[2] | minterm[4] | minterm[7];
      c_bit   = minterm[3] | minterm[5] | minterm[6] | minterm[7];
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and datapath strobes
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_bit  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST_BIT) begin
               last_bit  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Status flags registered from the next state so they track state exactly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt == RUN);
         done <= (state_nxt == DONE);
      end
   end

   // Operand shifters, running carry, bit counter, result and carry-out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         // Subtract is a + ~b + 1: invert b and seed the carry with 1
         a_sh  <= a;
         b_sh  <= sub ? ~b : b;
         carry <= sub;
         cnt   <= '0;
         sum   <= '0;
      end else if (state == RUN) begin
         sum   <= {s_bit, sum[WIDTH-1:1]};
         carry <= c_bit;
         a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
         cnt   <= cnt + CNT_W'(1);
         if (last_bit) begin
            cout <= c_bit;
         end
      end
   end

`ifdef SERIAL_FA_OVF_EN
   // During the MSB cycle the carry register holds the carry into the MSB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (accept) begin
         ovf <= 1'b0;
      end else if (last_bit) begin
         ovf <= carry ^ c_bit;
      end
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_fa_adder.sv
// tb_serial_fa_adder: self-checking bench for serial_fa_adder (WIDTH=8).
// Directed cases plus randomized operations checked against an arithmetic
// reference model; overflow expectations follow SERIAL_FA_OVF_EN.
module tb_serial_fa_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_cmp = 0;
   int n_err = 0;

   serial_fa_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic o);
      int ux;
      int uy;
      int sx;
      int sy;
      int sr;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (!s) begin
         r  = W'(ux + uy);
         c  = (ux + uy) > 255;
         sr = sx + sy;
      end else begin
         r  = W'(ux - uy);
         c  = (ux >= uy);
         sr = sx - sy;
      end
      o = (sr > 127) || (sr < -128);
`ifndef SERIAL_FA_OVF_EN
      o = 1'b0;
`endif
   endfunction

   // Waits for done (bounded); returns edge count including the accept edge
   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // One full operation; optionally poke start during the DONE cycle
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                         input string tag, input bit poke_done);
      logic [W-1:0] er;
      logic         ec;
      logic         eo;
      int           lat;
      model(ta, tb, ts, er, ec, eo);
      @(negedge clk);
      a = ta; b = tb; sub = ts; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      check({tag, ".busy_run"}, 32'(busy), 32'd1);
      wait_done(lat);
      check({tag, ".latency"}, 32'(lat), 32'(W + 1));
      check({tag, ".sum"}, 32'(sum), 32'(er));
      check({tag, ".cout"}, 32'(cout), 32'(ec));
      check({tag, ".ovf"}, 32'(ovf), 32'(eo));
      check({tag, ".busy_done"}, 32'(busy), 32'd0);
      if (poke_done) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         check({tag, ".start_in_done_ignored"}, 32'(busy), 32'd0);
         check({tag, ".done_pulse"}, 32'(done), 32'd0);
         repeat (3) @(posedge clk);
         #1;
         check({tag, ".sum_hold"}, 32'(sum), 32'(er));
         check({tag, ".cout_hold"}, 32'(cout), 32'(ec));
      end else begin
         @(posedge clk); #1;
         check({tag, ".done_pulse"}, 32'(done), 32'd0);
      end
   endtask

   initial begin : main
      int lat;
      int ndone;
      logic [W-1:0] ovf_exp_7f;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check("reset.sum", 32'(sum), 32'd0);
      check("reset.cout", 32'(cout), 32'd0);
      check("reset.ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed arithmetic cases
      run_op(8'h35, 8'h4A, 1'b0, "add", 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, "wrap", 1'b0);
      run_op(8'h7F, 8'h01, 1'b0, "sovf", 1'b1);
`ifdef SERIAL_FA_OVF_EN
      ovf_exp_7f = 8'h01;
`else
      ovf_exp_7f = 8'h00;
`endif
      check("sovf.ovf_direct", 32'(ovf), 32'(ovf_exp_7f));
      check("sovf.sum_direct", 32'(sum), 32'h80);
      run_op(8'h10, 8'h20, 1'b1, "sub_borrow", 1'b0);
      run_op(8'h80, 8'h01, 1'b1, "sub_ovf", 1'b0);

      // Busy lockout: start held high, a changed mid-run
      @(negedge clk);
      a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;
      a = 8'hAA;
      lat = 4;
      ndone = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (busy !== 1'b1 && done !== 1'b1) ndone++;
      end
      check("lock.latency", 32'(lat), 32'(W + 1));
      check("lock.no_early_idle", 32'(ndone), 32'd0);
      check("lock.sum", 32'(sum), 32'h03);
      @(posedge clk); #1;
      check("lock.done_ignored_busy", 32'(busy), 32'd0);
      check("lock.done_ignored_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("lock.reaccept", 32'(busy), 32'd1);
      start = 1'b0;
      wait_done(lat);
      check("lock.re_latency", 32'(lat), 32'(W + 1));
      check("lock.re_sum", 32'(sum), 32'hAC);
      @(posedge clk); #1;

      // Reset mid-run: outputs clear immediately, no done pulse follows
      @(negedge clk);
      a = 8'h55; b = 8'h33; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid.busy", 32'(busy), 32'd0);
      check("rstmid.done", 32'(done), 32'd0);
      check("rstmid.sum", 32'(sum), 32'd0);
      check("rstmid.cout", 32'(cout), 32'd0);
      check("rstmid.ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (W + 3) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      check("rstmid.no_done", 32'(ndone), 32'd0);
      run_op(8'h0F, 8'h01, 1'b0, "post_rst", 1'b0);

      // Randomized operations against the model
      for (int i = 0; i < 24; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i), (i % 4) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_fa_adder.md
# serial_fa_adder

Bit-serial, parametrised adder/subtractor built around a single decoder-based full-adder cell: a 3-to-8 minterm decoder over (a_bit, b_bit, carry), with sum = OR(m1,m2,m4,m7) and carry = OR(m3,m5,m6,m7). Operands are loaded in parallel, processed LSB-first one bit per clock, and returned in parallel with carry-out. It is the sequential, multi-bit successor to the combinational decoder full adder and serves as the arithmetic lab block behind the comparator, decoder and mux exercises.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- sum  output  WIDTH  result; holds until the next accepted start.
- cout  output  1  final carry; for sub, 1 means no borrow.
- ovf  output  1  signed overflow; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1 latches: A shift reg <= a; B shift reg <= sub ? ~b : b; carry <= sub; bit counter <= 0; sum <= 0; ovf <= 0. Next state is RUN.
- RUN, each cycle:
  - Decoder inputs are (A[0], B[0], carry), MSB first, giving minterms m0..m7.
  - Shift the sum bit into the sum register from the MSB side (right shift).
  - carry <= carry bit.
  - Shift A and B right by one.
  - Counter increments.
- RUN with counter == WIDTH-1: that cycle processes the MSB. Capture cout <= the carry bit and ovf (if enabled). Next state is DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE unconditionally. A start seen during DONE is ignored.
- start during RUN or DONE is ignored; no queuing.
- Changes to a, b and sub after acceptance have no effect.
- Counter width is $clog2(WIDTH). No intermediate value ever exceeds WIDTH bits plus carry.
- sum, cout and ovf are stable from the DONE cycle until the cycle after the next accepted start.
  - Partial results are visible on sum during RUN. Consumers sample on done.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry=0, counter=0.
- Reset is asynchronous. Asserting rst mid-RUN aborts immediately with no done pulse. The first start after rst deasserts is accepted normally.
- Start accepted at edge T. busy=1 from T through T+WIDTH. done=1 during cycle T+WIDTH+1 (the cycle after the last RUN cycle). busy=0 when done=1.
- Latency from start to done is WIDTH+1 clocks. Minimum start-to-start spacing is WIDTH+2 clocks.
- No combinational path from inputs to outputs.

## Configuration
- SERIAL_FA_OVF_EN defined:
  - During the MSB cycle, ovf <= carry_into_msb XOR carry_out_of_msb.
  - The decoder carry-in to the MSB bit is registered for this purpose.
- SERIAL_FA_OVF_EN undefined:
  - ovf is tied to 0.
  - No overflow logic is synthesised.
  - The port remains present.

## Test plan
All cases use WIDTH=8 and SERIAL_FA_OVF_EN defined unless noted.
- Add: a=0x35, b=0x4A, sub=0 -> done 9 clocks after start; sum=0x7F, cout=0, ovf=0.
- Wrap: a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Signed overflow: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- Subtract: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0 (borrow), ovf=0. Also a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Busy lockout: start held high throughout a=0x01, b=0x02, with a changed to 0xAA at cycle 3 -> one done only; sum=0x03. The next acceptance occurs in IDLE after done.
- Reset mid-op: rst pulsed at RUN cycle 4 -> all outputs 0 at once, no done pulse. A subsequent a=0x0F + b=0x01 gives 0x10.
- Macro off: rebuild without SERIAL_FA_OVF_EN and rerun a=0x7F + b=0x01 -> sum=0x80, ovf=0.
